pipeline_hazard_ctrl: RTL

- Central stall/flush sequencer for the 5-stage RV32I pipeline.
- Detects load-use hazards in ID, squashes wrong-path instructions after a taken branch resolved in EX, and freezes the whole pipeline while data memory is not ready.
- Drives the `stall` input of the main controller plus the pipeline-register write/flush enables.
- Keeps saturating stall/flush counters and a sticky memory-timeout error.

---
 rtl/pipeline_hazard_ctrl_pkg.sv | 25 ++
 rtl/pipeline_hazard_ctrl_hazard_detect.sv | 23 ++
 rtl/pipeline_hazard_ctrl.sv | 110 +++++++++++
 3 files changed

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// rtl/pipeline_hazard_ctrl_pkg.sv - opcodes, FSM encodings and source-usage decode for the hazard controller
package pipeline_hazard_ctrl_pkg;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_L   = 7'b0000011;
  localparam logic [6:0] OP_S   = 7'b0100011;
  localparam logic [6:0] OP_B   = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_LUI = 7'b0110111;

  typedef enum logic [0:0] {
    HZ_RUN      = 1'b0,
    HZ_MEM_WAIT = 1'b1
  } hz_state_e;

  function automatic logic op_uses_rs1(input logic [6:0] op);
    return (op == OP_R) || (op == OP_I) || (op == OP_L) || (op == OP_S) || (op == OP_B);
  endfunction

  function automatic logic op_uses_rs2(input logic [6:0] op);
    return (op == OP_R) || (op == OP_S) || (op == OP_B);
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_hazard_detect.sv
// rtl/pipeline_hazard_ctrl_hazard_detect.sv - combinational load-use hazard detection for ID vs EX
module hazard_detect
  import pipeline_hazard_ctrl_pkg::*;
(
  input  logic [6:0] id_opcode,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic [4:0] ex_rd,
  input  logic       ex_memread,
  output logic       load_use
);

  logic uses_rs1;
  logic uses_rs2;

  assign uses_rs1 = op_uses_rs1(id_opcode);
  assign uses_rs2 = op_uses_rs2(id_opcode);

  // x0 is never a real dependency, even when a load targets it
  assign load_use = ex_memread && (ex_rd != 5'd0) &&
                    ((uses_rs1 && (ex_rd == id_rs1)) || (uses_rs2 && (ex_rd == id_rs2)));

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - stall/flush sequencer with memory-wait FSM, counters and timeout flag
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int CNT_W       = 16,
  parameter int MEM_TIMEOUT = 255,
  parameter int TO_W        = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       id_opcode,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_memread,
  input  logic             ex_branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             ctrl_stall,
  output logic             pipe_hold,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic             mem_err
);

  localparam logic [TO_W-1:0]  TO_MAX  = TO_W'(MEM_TIMEOUT);
  localparam logic [TO_W-1:0]  TO_ONE  = TO_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  hz_state_e       state;
  logic [TO_W-1:0] wait_cnt;
  logic            load_use;
  logic            mem_stall;
  logic            flush_evt;

  hazard_detect u_hazard_detect (
    .id_opcode  (id_opcode),
    .id_rs1     (id_rs1),
    .id_rs2     (id_rs2),
    .ex_rd      (ex_rd),
    .ex_memread (ex_memread),
    .load_use   (load_use)
  );

  assign mem_stall = mem_req && !mem_ready;
  assign flush_evt = !rst && !mem_stall && ex_branch_taken;

  always_comb begin
    pc_write   = 1'b1;
    ifid_write = 1'b1;
    ifid_flush = 1'b0;
    ctrl_stall = 1'b0;
    pipe_hold  = 1'b0;
    if (rst) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      ifid_flush = 1'b1;
      ctrl_stall = 1'b1;
    end else if (mem_stall) begin
      // freeze everything; branch and load-use re-evaluate once memory answers
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      pipe_hold  = 1'b1;
    end else if (ex_branch_taken) begin
      ifid_flush = 1'b1;
      ctrl_stall = 1'b1;
    end else if (load_use) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      ctrl_stall = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= HZ_RUN;
      wait_cnt  <= '0;
      stall_cnt <= '0;
      flush_cnt <= '0;
      mem_err   <= 1'b0;
    end else begin
      case (state)
        HZ_RUN: begin
          if (mem_stall) begin
            state    <= HZ_MEM_WAIT;
            wait_cnt <= '0;
          end
        end
        HZ_MEM_WAIT: begin
          if (!mem_stall) begin
            state <= HZ_RUN;
          end else begin
            // counter parks at the limit so a long wait never wraps back under it
            if (wait_cnt != TO_MAX) wait_cnt <= wait_cnt + TO_ONE;
            if ((wait_cnt == TO_MAX) || ((wait_cnt + TO_ONE) == TO_MAX)) mem_err <= 1'b1;
          end
        end
        default: state <= HZ_RUN;
      endcase

      if (!pc_write && (stall_cnt != CNT_MAX)) stall_cnt <= stall_cnt + CNT_ONE;
      if (flush_evt && (flush_cnt != CNT_MAX)) flush_cnt <= flush_cnt + CNT_ONE;
    end
  end

endmodule
